fpu_arbiter: RTL

- Shares one FPU datapath between two requesters: the integer pipeline issue port (port 0) and the load/store writeback port (port 1).
- The FPU has inputs A, B and Sel[1:0], and output Out_0. Sel encodes 0 = add, 1 = sub, 2 = mul, 3 = compare.
- The FPU is treated as a non-pipelined unit with fixed latency FPU_LAT.
- Grants round-robin, holds FPU operands stable for the whole operation, captures the result, and returns it to the owner over a valid/ready response handshake.

---
 rtl/fpu_arbiter_if.sv | 45 ++++
 rtl/fpu_arbiter.sv | 103 ++++++++++
 2 files changed

// File: rtl/fpu_arbiter_if.sv
// Bundle of request, FPU and response signals shared by the FPU arbiter and its clients.
// The arbiter takes the slave view; the requesters and the FPU together form the master view.
interface fpu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [1:0]  req0_sel;

  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [1:0]  req1_sel;

  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [1:0]  fpu_sel;
  logic [31:0] fpu_out;

  logic [31:0] rsp_data;
  logic        rsp0_valid;
  logic        rsp1_valid;
  logic        rsp0_ready;
  logic        rsp1_ready;
  logic        busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    input  fpu_out, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output fpu_a, fpu_b, fpu_sel,
    output rsp_data, rsp0_valid, rsp1_valid, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    output fpu_out, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  fpu_a, fpu_b, fpu_sel,
    input  rsp_data, rsp0_valid, rsp1_valid, busy
  );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one fixed-latency, non-pipelined FPU between two requesters.
// Operands are held for the whole operation; the result is returned over a valid/ready handshake.
module fpu_arbiter #(
  parameter int FPU_LAT = 5,  // 1..15, and 2**CNT_W must exceed it
  parameter int CNT_W   = 4
) (
  input logic          clk,
  input logic          rst,
  fpu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FPU_LAT - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             owner;
  logic             last_grant;
  logic             grant_port;
  logic             grant;
  logic             capture;

  // A lone requester always wins; on a tie the port that lost last time goes.
  always_comb begin
    grant_port = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) grant_port = ~last_grant;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx       = state;
    grant          = 1'b0;
    capture        = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    bus.busy       = 1'b0;
    unique case (state)
      IDLE: begin
        // Ready is masked during reset so nothing looks accepted while the block is held.
        if ((bus.req0_valid || bus.req1_valid) && !rst) begin
          grant          = 1'b1;
          bus.req0_ready = ~grant_port;
          bus.req1_ready = grant_port;
          state_nx       = EXEC;
        end
      end
      EXEC: begin
        bus.busy = 1'b1;
        if (cnt == '0) begin
          capture  = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        bus.busy       = 1'b1;
        bus.rsp0_valid = ~owner;
        bus.rsp1_valid = owner;
        if (owner ? bus.rsp1_ready : bus.rsp0_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      bus.fpu_a    <= '0;
      bus.fpu_b    <= '0;
      bus.fpu_sel  <= '0;
      bus.rsp_data <= '0;
    end else begin
      if (grant) begin
        owner       <= grant_port;
        last_grant  <= grant_port;
        bus.fpu_a   <= grant_port ? bus.req1_a   : bus.req0_a;
        bus.fpu_b   <= grant_port ? bus.req1_b   : bus.req0_b;
        bus.fpu_sel <= grant_port ? bus.req1_sel : bus.req0_sel;
        cnt         <= CNT_LOAD;
      end else if (state == EXEC && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      // FPU inputs stay untouched outside a grant, so they are stable for FPU_LAT cycles here.
      if (capture) bus.rsp_data <= bus.fpu_out;
    end
  end

endmodule
